// File: rtl/tron_pkg.sv
// tron_pkg: shared direction, state and winner encodings plus screen geometry for the tron control slice.
package tron_pkg;
  typedef enum logic [2:0] {UP = 3'b000, DOWN = 3'b001, LEFT = 3'b010, RIGHT = 3'b011, STOP = 3'b100} player_dir_t;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNTDOWN = 2'd1, PLAY = 2'd2, OVER = 2'd3} game_state_t;
  typedef enum logic [1:0] {WIN_NONE = 2'd0, WIN_P1 = 2'd1, WIN_P2 = 2'd2, WIN_DRAW = 2'd3} winner_t;
  localparam int SCREEN_ROWS = 600;
  localparam int SCREEN_COLS = 800;
  // Opposite pairs differ only in bit 0; STOP has no opposite.
  function automatic player_dir_t opposite(input player_dir_t d);
    return d == STOP ? STOP : player_dir_t'(d ^ 3'b001);
  endfunction
endpackage

// File: rtl/tron_game_ctrl_if.sv
// tron_game_ctrl_if: raw player/scan inputs and per-frame control outputs of the game controller.
interface tron_game_ctrl_if;
  import tron_pkg::*;
  logic        start;
  logic [3:0]  p1_btn, p2_btn;
  logic [9:0]  row, col;
  logic        p1_crash, p2_crash;
  player_dir_t p1_info, p2_info;
  logic        dflt;
  game_state_t game_state;
  winner_t     winner;
  logic [3:0]  p1_score, p2_score;
  logic        frame_tick;
  modport master (
    output start, p1_btn, p2_btn, row, col, p1_crash, p2_crash,
    input  p1_info, p2_info, dflt, game_state, winner, p1_score, p2_score, frame_tick
  );
  modport slave (
    input  start, p1_btn, p2_btn, row, col, p1_crash, p2_crash,
    output p1_info, p2_info, dflt, game_state, winner, p1_score, p2_score, frame_tick
  );
endinterface

// File: rtl/tron_game_ctrl_dir_latch.sv
// dir_latch: synchronizes one player's buttons and tracks pending vs. frame-committed direction.
module dir_latch
  import tron_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  btn_i,
  input  logic        en_i,
  input  logic        commit_i,
  input  logic        init_i,
  input  player_dir_t init_dir_i,
  output player_dir_t dir_o
);
  logic [3:0] meta_q, sync_q;
  player_dir_t pend_q, pend_d, dir_q, dir_d, dec;
  always_comb begin
    dec = sync_q == 4'b1000 ? UP :
          sync_q == 4'b0100 ? DOWN :
          sync_q == 4'b0010 ? LEFT :
          sync_q == 4'b0001 ? RIGHT : STOP;
    // Reversal is judged against what is on screen, not against the pending choice.
    pend_d = init_i ? init_dir_i :
             en_i && dec != STOP && dec != opposite(dir_q) ? dec : pend_q;
    dir_d = init_i ? init_dir_i : commit_i ? pend_q : dir_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      pend_q <= STOP;
      dir_q  <= STOP;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      pend_q <= pend_d;
      dir_q  <= dir_d;
    end
  end
  assign dir_o = dir_q;
endmodule

// File: rtl/tron_game_ctrl.sv
// tron_game_ctrl: round FSM, frame tick, crash arbitration and scoring ahead of the draw stage.
module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int COUNT_FRAMES = 120,
  parameter int OVER_FRAMES  = 180,
  parameter int WIN_SCORE    = 5,
  parameter int LAST_ROW     = SCREEN_ROWS - 1,
  parameter int LAST_COL     = SCREEN_COLS - 1
) (
  input logic clock,
  input logic reset,
  tron_game_ctrl_if.slave bus
);
  game_state_t state_q, state_d;
  winner_t win_q, win_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] sc1_q, sc1_d, sc2_q, sc2_d;
  logic [2:0] st_q;
  logic tick_q, c1_q, c2_q;
  logic rise, play, crash1, crash2, any_crash, commit, init, match_done;
  player_dir_t p1_dir, p2_dir;
  assign rise       = st_q[1] & ~st_q[2];
  assign play       = state_q == PLAY;
  // A crash landing on the tick cycle itself still counts for this frame.
  assign crash1     = c1_q | bus.p1_crash;
  assign crash2     = c2_q | bus.p2_crash;
  assign any_crash  = crash1 | crash2;
  assign commit     = play & tick_q & ~any_crash;
  assign init       = state_d == PLAY && !play;
  assign match_done = sc1_q == 4'(WIN_SCORE) || sc2_q == 4'(WIN_SCORE);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= WIN_NONE;
      sc1_q   <= '0;
      sc2_q   <= '0;
      st_q    <= '0;
      tick_q  <= 1'b0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      sc1_q   <= sc1_d;
      sc2_q   <= sc2_d;
      st_q    <= {st_q[1:0], bus.start};
      tick_q  <= bus.row == 10'(LAST_ROW) && bus.col == 10'(LAST_COL);
      c1_q    <= play & ~tick_q & crash1;
      c2_q    <= play & ~tick_q & crash2;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    sc1_d   = sc1_q;
    sc2_d   = sc2_q;
    case (state_q)
      IDLE: if (rise) begin
        state_d = COUNTDOWN;
        cnt_d   = '0;
        if (match_done) begin
          sc1_d = '0;
          sc2_d = '0;
          win_d = WIN_NONE;
        end
      end
      COUNTDOWN: if (tick_q) begin
        state_d = cnt_q == 16'(COUNT_FRAMES - 1) ? PLAY : COUNTDOWN;
        cnt_d   = cnt_q == 16'(COUNT_FRAMES - 1) ? '0 : cnt_q + 16'd1;
      end
      PLAY: if (tick_q && any_crash) begin
        state_d = OVER;
        cnt_d   = '0;
        win_d   = crash1 && crash2 ? WIN_DRAW : crash1 ? WIN_P2 : WIN_P1;
        sc1_d   = crash2 && !crash1 ? sc1_q + 4'(sc1_q != 4'hf) : sc1_q;
        sc2_d   = crash1 && !crash2 ? sc2_q + 4'(sc2_q != 4'hf) : sc2_q;
      end
      default: if (tick_q) begin
        state_d = cnt_q != 16'(OVER_FRAMES - 1) ? OVER : match_done ? IDLE : COUNTDOWN;
        cnt_d   = cnt_q == 16'(OVER_FRAMES - 1) ? '0 : cnt_q + 16'd1;
      end
    endcase
  end
  always_comb begin
    bus.dflt       = state_q == IDLE || state_q == COUNTDOWN;
    bus.p1_info    = play ? p1_dir : STOP;
    bus.p2_info    = play ? p2_dir : STOP;
    bus.game_state = state_q;
    bus.winner     = win_q;
    bus.p1_score   = sc1_q;
    bus.p2_score   = sc2_q;
    bus.frame_tick = tick_q;
  end
  dir_latch u_p1 (
    .clock(clock), .reset(reset), .btn_i(bus.p1_btn), .en_i(play),
    .commit_i(commit), .init_i(init), .init_dir_i(RIGHT), .dir_o(p1_dir)
  );
  dir_latch u_p2 (
    .clock(clock), .reset(reset), .btn_i(bus.p2_btn), .en_i(play),
    .commit_i(commit), .init_i(init), .init_dir_i(LEFT), .dir_o(p2_dir)
  );
endmodule

// File: tb/tb_tron_game_ctrl.sv
// tb_tron_game_ctrl: frame-level vector table plus directed start-latency and mid-play reset sequences.
module tb_tron_game_ctrl;
  import tron_pkg::*;
  typedef struct {
    logic       st;
    logic [3:0] b1, b2;
    logic       c1, c2, late;
    logic [1:0] gs;
    logic [2:0] i1, i2;
    logic       df;
    logic [1:0] w;
    logic [3:0] s1, s2;
  } vec_t;
  localparam logic [3:0] BU = 4'b1000, BD = 4'b0100, BL = 4'b0010, BR = 4'b0001;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int pos = 0, tests = 0, fails = 0;
  logic [1:0] pv_gs;
  logic [2:0] pv_i1, pv_i2;
  vec_t tbl [35];
  tron_game_ctrl_if bus ();
  tron_game_ctrl #(.COUNT_FRAMES(2), .OVER_FRAMES(2), .WIN_SCORE(2)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, want %0d", nm, n, act, exp);
    end
  endtask
  // 32-cycle synthetic frame over the tail of rows 598/599; step i drives scan slot i, slot 29 is (599,799).
  task automatic step();
    int p;
    @(negedge clock);
    p = (pos + 2) % 32;
    bus.row = p < 16 ? 10'd598 : 10'd599;
    bus.col = 10'(784 + p % 16);
    pos = (pos + 1) % 32;
  endtask
  task automatic run_frame(input int n, input vec_t t);
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 14 || i == 29) chk("tick_low", n, bus.frame_tick, 0);
      if (i == 30) begin
        chk("tick_high", n, bus.frame_tick, 1);
        if (!t.st) begin
          chk("hold_state", n, bus.game_state, pv_gs);
          chk("hold_p1", n, bus.p1_info, pv_i1);
          chk("hold_p2", n, bus.p2_info, pv_i2);
        end
      end
      if (i == 31) begin
        chk("state", n, bus.game_state, t.gs);
        chk("p1_info", n, bus.p1_info, t.i1);
        chk("p2_info", n, bus.p2_info, t.i2);
        chk("dflt", n, bus.dflt, t.df);
        chk("winner", n, bus.winner, t.w);
        chk("p1_score", n, bus.p1_score, t.s1);
        chk("p2_score", n, bus.p2_score, t.s2);
      end
      bus.start    = t.st && i >= 2 && i < 8;
      bus.p1_btn   = (t.late ? i >= 28 : (i >= 2 && i < 8)) ? t.b1 : 4'b0;
      bus.p2_btn   = (t.late ? i >= 28 : (i >= 2 && i < 8)) ? t.b2 : 4'b0;
      bus.p1_crash = t.c1 && i == 10;
      bus.p2_crash = t.c2 && i == 10;
    end
    pv_gs = t.gs;
    pv_i1 = t.i1;
    pv_i2 = t.i2;
  endtask
  initial begin
    bus.start = 1'b0; bus.p1_btn = '0; bus.p2_btn = '0;
    bus.p1_crash = 1'b0; bus.p2_crash = 1'b0; bus.row = '0; bus.col = '0;
    tbl[0]  = '{0, 0,  0,       0, 0, 0, PLAY,      RIGHT, LEFT,  0, 0, 0, 0};
    tbl[1]  = '{0, BU, 0,       0, 0, 0, PLAY,      UP,    LEFT,  0, 0, 0, 0};
    tbl[2]  = '{0, BD, 0,       0, 0, 0, PLAY,      UP,    LEFT,  0, 0, 0, 0};
    tbl[3]  = '{0, 0,  BL | BU, 0, 0, 0, PLAY,      UP,    LEFT,  0, 0, 0, 0};
    tbl[4]  = '{0, BL, BU,      0, 0, 0, PLAY,      LEFT,  UP,    0, 0, 0, 0};
    tbl[5]  = '{0, 0,  BR,      0, 0, 1, PLAY,      LEFT,  UP,    0, 0, 0, 0};
    tbl[6]  = '{0, 0,  0,       0, 0, 0, PLAY,      LEFT,  RIGHT, 0, 0, 0, 0};
    tbl[7]  = '{0, 0,  0,       0, 1, 0, OVER,      STOP,  STOP,  0, 1, 1, 0};
    tbl[8]  = '{0, 0,  0,       0, 0, 0, OVER,      STOP,  STOP,  0, 1, 1, 0};
    tbl[9]  = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 1, 1, 0};
    tbl[10] = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 1, 1, 0};
    tbl[11] = '{0, 0,  0,       0, 0, 0, PLAY,      RIGHT, LEFT,  0, 1, 1, 0};
    tbl[12] = '{0, 0,  0,       1, 1, 0, OVER,      STOP,  STOP,  0, 3, 1, 0};
    tbl[13] = '{0, 0,  0,       0, 0, 0, OVER,      STOP,  STOP,  0, 3, 1, 0};
    tbl[14] = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 3, 1, 0};
    tbl[15] = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 3, 1, 0};
    tbl[16] = '{0, 0,  0,       0, 0, 0, PLAY,      RIGHT, LEFT,  0, 3, 1, 0};
    tbl[17] = '{0, 0,  0,       1, 0, 0, OVER,      STOP,  STOP,  0, 2, 1, 1};
    tbl[18] = '{0, 0,  0,       0, 0, 0, OVER,      STOP,  STOP,  0, 2, 1, 1};
    tbl[19] = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 2, 1, 1};
    tbl[20] = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 2, 1, 1};
    tbl[21] = '{0, 0,  0,       0, 0, 0, PLAY,      RIGHT, LEFT,  0, 2, 1, 1};
    tbl[22] = '{0, 0,  0,       0, 1, 0, OVER,      STOP,  STOP,  0, 1, 2, 1};
    tbl[23] = '{0, 0,  0,       0, 0, 0, OVER,      STOP,  STOP,  0, 1, 2, 1};
    tbl[24] = '{0, 0,  0,       0, 0, 0, IDLE,      STOP,  STOP,  1, 1, 2, 1};
    tbl[25] = '{0, 0,  0,       1, 1, 0, IDLE,      STOP,  STOP,  1, 1, 2, 1};
    tbl[26] = '{1, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 0, 0, 0};
    tbl[27] = '{0, 0,  0,       0, 0, 0, PLAY,      RIGHT, LEFT,  0, 0, 0, 0};
    tbl[28] = '{1, 0,  0,       0, 0, 0, PLAY,      RIGHT, LEFT,  0, 0, 0, 0};
    tbl[29] = '{0, 0,  0,       0, 1, 0, OVER,      STOP,  STOP,  0, 1, 1, 0};
    tbl[30] = '{0, 0,  0,       0, 0, 0, OVER,      STOP,  STOP,  0, 1, 1, 0};
    tbl[31] = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 1, 1, 0};
    tbl[32] = '{0, 0,  0,       0, 0, 0, COUNTDOWN, STOP,  STOP,  1, 1, 1, 0};
    tbl[33] = '{0, 0,  0,       0, 0, 0, PLAY,      RIGHT, LEFT,  0, 1, 1, 0};
    tbl[34] = '{0, 0,  0,       1, 1, 0, IDLE,      STOP,  STOP,  1, 0, 0, 0};
    repeat (3) step();
    chk("rst_state", 0, bus.game_state, IDLE);
    chk("rst_p1", 0, bus.p1_info, STOP);
    chk("rst_p2", 0, bus.p2_info, STOP);
    chk("rst_dflt", 0, bus.dflt, 1);
    chk("rst_winner", 0, bus.winner, 0);
    chk("rst_s1", 0, bus.p1_score, 0);
    chk("rst_s2", 0, bus.p2_score, 0);
    chk("rst_tick", 0, bus.frame_tick, 0);
    reset = 1'b0;
    pos = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 4) chk("start_lat2", 0, bus.game_state, IDLE);
      if (i == 5) chk("start_lat3", 0, bus.game_state, COUNTDOWN);
      if (i == 31) begin
        chk("cd_state", 0, bus.game_state, COUNTDOWN);
        chk("cd_dflt", 0, bus.dflt, 1);
        chk("cd_p1", 0, bus.p1_info, STOP);
      end
      bus.start = i >= 2 && i < 8;
    end
    pv_gs = COUNTDOWN;
    pv_i1 = STOP;
    pv_i2 = STOP;
    for (int n = 0; n < 34; n++) run_frame(n, tbl[n]);
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 30) chk("pre_rst_state", 0, bus.game_state, PLAY);
      if (i == 31) begin
        chk("mid_rst_state", 0, bus.game_state, IDLE);
        chk("mid_rst_p1", 0, bus.p1_info, STOP);
        chk("mid_rst_p2", 0, bus.p2_info, STOP);
        chk("mid_rst_dflt", 0, bus.dflt, 1);
        chk("mid_rst_winner", 0, bus.winner, 0);
        chk("mid_rst_s1", 0, bus.p1_score, 0);
        chk("mid_rst_s2", 0, bus.p2_score, 0);
      end
      reset = i == 30;
    end
    pv_gs = IDLE;
    pv_i1 = STOP;
    pv_i2 = STOP;
    run_frame(34, tbl[34]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tron_game_ctrl.md
Name: tron_game_ctrl

Overview:
- Upstream control stage for the object draw/update block: turns raw player buttons into per-frame direction codes (p1_info/p2_info) and the default/respawn strobe (dflt).
- Runs the round state machine: idle, countdown, play, over.
- Consumes per-player crash pulses from the collision logic, decides the round winner, and keeps scores.
- All direction changes commit only at the frame boundary, so the draw stage sees stable inputs for a whole frame.

Parameters:
- COUNT_FRAMES, 120, frames spent in COUNTDOWN before PLAY.
- OVER_FRAMES, 180, frames spent in OVER before returning to IDLE.
- WIN_SCORE, 5, score that ends the match.
- LAST_ROW, 599, row of the frame-end pixel.
- LAST_COL, 799, col of the frame-end pixel.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  raw start button, asynchronous to clock
- p1_btn  in  4  raw P1 buttons {up,down,left,right}, asynchronous
- p2_btn  in  4  raw P2 buttons, same order
- row  in  10  current display row
- col  in  10  current display col
- p1_crash  in  1  single-cycle crash pulse for P1
- p2_crash  in  1  single-cycle crash pulse for P2
- p1_info  out  3  P1 committed direction (player_dir_t)
- p2_info  out  3  P2 committed direction (player_dir_t)
- dflt  out  1  1 = draw stage loads start positions
- game_state  out  2  IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw
- p1_score  out  4  P1 round wins
- p2_score  out  4  P2 round wins
- frame_tick  out  1  registered pulse, one cycle after row==LAST_ROW && col==LAST_COL

Behaviour:
- Reset (synchronous, active-high; clock is clock): state IDLE, p1_info=p2_info=STOP, dflt=1, winner=0, scores 0, frame_tick=0, all synchronizers, pending registers, crash flags and counters cleared.
- Inputs: start and buttons pass through 2-flop synchronizers. start acts on its rising edge after synchronization, 3 cycles after the pin rises.
- Button decode: a synchronized button vector with exactly one bit set maps to UP/DOWN/LEFT/RIGHT. Zero or more than one bit set leaves pending unchanged.
- No-reverse rule: a decoded direction is ignored if it is the opposite of the committed direction (UP<->DOWN, LEFT<->RIGHT). STOP has no opposite.
- Pending vs. committed: the pending direction updates on any cycle during PLAY. The committed output (pX_info) loads pending on the cycle frame_tick=1 in PLAY, visible the following cycle. A press on the tick cycle applies at the next frame.
- Crash flags: sticky; set by pX_crash in PLAY, cleared on the cycle after frame_tick is processed. Crash pulses outside PLAY are ignored.
- FSM, all transitions on frame_tick except IDLE->COUNTDOWN:
  - IDLE: dflt=1, infos STOP. Start edge -> COUNTDOWN, frame counter=0. If a prior match ended, scores and winner clear on this edge.
  - COUNTDOWN: dflt=1, infos STOP. Counter increments per tick; at count COUNT_FRAMES-1 -> PLAY. On entry to PLAY, committed and pending are set to P1=RIGHT and P2=LEFT; dflt drops to 0 in the same cycle.
  - PLAY: dflt=0. On a tick with any crash flag set -> OVER and that tick's direction commit is suppressed.
    - Only P1 flag set: winner=2, p2_score+1.
    - Only P2 flag set: winner=1, p1_score+1.
    - Both set: winner=3, no score change.
  - OVER: infos STOP, dflt=0 (trails stay visible). After OVER_FRAMES ticks:
    - If either score equals WIN_SCORE -> IDLE, scores held until the next start edge.
    - Otherwise -> COUNTDOWN.
- Scores saturate at 15.
- Start edges outside IDLE are ignored.
- Reset mid-PLAY returns to IDLE in the next cycle regardless of pending ticks.

Decomposition:
- Shared package tron_pkg: player_dir_t (UP=3'b000, DOWN=3'b001, LEFT=3'b010, RIGHT=3'b011, STOP=3'b100), game_state_t, winner encoding, screen constants 600/800.
- One sub-module, dir_latch: synchronizer, decode, no-reverse check, and pending/committed registers. Instantiated twice.

Test Plan:
All scenarios use COUNT_FRAMES=2, OVER_FRAMES=2, WIN_SCORE=2, and a bench-driven row/col scan.
- Reset, then start pulse -> state COUNTDOWN 3 cycles later. After 2 ticks -> PLAY with p1_info=RIGHT(011), p2_info=LEFT(010), dflt=0.
- In PLAY, P1 presses UP mid-frame -> p1_info stays RIGHT until the cycle after the next frame_tick, then becomes UP(000). P1 then presses DOWN -> ignored, stays UP.
- P2 presses LEFT+UP together -> no change. A press landing exactly on the tick cycle -> commits at the following tick.
- p2_crash pulse mid-frame -> at the tick, state OVER, winner=1, p1_score=1, both infos STOP. After 2 ticks -> COUNTDOWN.
- p1_crash and p2_crash in the same frame -> winner=3, scores unchanged. A second P1 round win -> p1_score=2, then IDLE after OVER; the next start clears scores to 0.
- Assert reset during PLAY -> next cycle state IDLE, infos STOP, dflt=1, scores 0. Crash pulses while in IDLE -> no state or score change.
